// File: rtl/vga_line_fetch.sv
// vga_line_fetch: double-buffered scanline fetcher for a VGA output stage.
// During horizontal blanking it reads one line of packed 2-pixel words from
// the framebuffer into a line buffer, while the other buffer feeds pixels
// out with a fixed two-cycle latency.
// Optional feature: define VGA_FETCH_UNDERRUN_CNT_EN to add the 8-bit
// saturating underrun_cnt output.
//
// Framebuffer read handshake: mem_req high means mem_addr is valid and held.
// A word transfers on any cycle where mem_req and mem_ack are both high, and
// mem_rdata is captured in that same cycle. The address then advances on the
// next cycle with mem_req staying high, until the last word of the line.
module vga_line_fetch #(
  parameter int ACTIVE_W  = 640,
  parameter int ACTIVE_H  = 480,
  parameter int V_LAST    = 500,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  output logic        RD,
  output logic        GD,
  output logic        BD,
  output logic        mem_req,
  output logic [17:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        underrun,
  input  logic        underrun_clr
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  ,
  output logic [7:0]  underrun_cnt
`endif
);

  localparam int W  = ACTIVE_W / 2;
  localparam int AW = (W > 1) ? $clog2(W) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(W - 1);
  localparam logic [9:0]    ACT_W10  = 10'(ACTIVE_W);
  localparam logic [9:0]    ACT_H10  = 10'(ACTIVE_H);
  localparam logic [8:0]    V_LAST9  = 9'(V_LAST);
  localparam logic [17:0]   W18      = 18'(W);
  localparam logic [17:0]   BASE18   = 18'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t          state_q;
  logic            mem_req_q;
  logic [17:0]     mem_addr_q;
  logic [AW-1:0]   word_idx_q;
  logic            wr_buf_q;
  logic [8:0]      fetch_line_q;
  logic            underrun_q, underrun_d;

  logic [8:0]      next_line;
  logic            trigger;
  logic [17:0]     start_addr;
  logic            in_fetch;
  logic            wr_en;
  logic            under_set;

  // Each stored word keeps only the two RGB triplets {odd, even}.
  logic [5:0]      line_buf [2][W];
  logic [5:0]      rd_word_q;
  logic            pix_blank;
  logic [AW-1:0]   rd_idx;
  logic            blank_q;
  logic            odd_q;
  logic [2:0]      rgb_q;

  // Bits 3 and 7 of each framebuffer word carry no pixel data.
  logic            unused_rdata_bits;
  assign unused_rdata_bits = mem_rdata[7] ^ mem_rdata[3];

  // Fetch trigger, start address, buffer write enable and underrun events.
  always_comb begin
    next_line  = (y == V_LAST9) ? 9'd0 : y + 9'd1;
    trigger    = (x == ACT_W10) && ({1'b0, next_line} < ACT_H10);
    start_addr = BASE18 + 18'(next_line) * W18;
    in_fetch   = (state_q == FETCH);
    // An ack arriving in the same cycle as a restart belongs to the old line.
    wr_en      = in_fetch && mem_ack && !trigger;
    under_set  = (in_fetch && trigger) ||
                 (in_fetch && (x == 10'd0) && ({1'b0, y} < ACT_H10) &&
                  (fetch_line_q == y));
  end

  // Fetch FSM: a trigger (re)starts a line, the last ack finishes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= BASE18;
      word_idx_q   <= '0;
      wr_buf_q     <= 1'b0;
      fetch_line_q <= '0;
    end else if (trigger) begin
      state_q      <= FETCH;
      mem_req_q    <= 1'b1;
      mem_addr_q   <= start_addr;
      word_idx_q   <= '0;
      wr_buf_q     <= next_line[0];
      fetch_line_q <= next_line;
    end else if (wr_en) begin
      mem_addr_q <= mem_addr_q + 18'd1;
      word_idx_q <= word_idx_q + 1'b1;
      if (word_idx_q == LAST_IDX) begin
        state_q   <= DONE;
        mem_req_q <= 1'b0;
      end
    end
  end

  // Line buffer write port: captures the acknowledged word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_buf[wr_buf_q][word_idx_q] <= {mem_rdata[6:4], mem_rdata[2:0]};
    end
  end

  // Pixel read address; out-of-range positions read word 0 and are blanked.
  always_comb begin
    pix_blank = (x >= ACT_W10) || ({1'b0, y} >= ACT_H10);
    rd_idx    = pix_blank ? '0 : x[AW:1];
  end

  // Registered line buffer read (first pipeline stage).
  always_ff @(posedge clk) begin
    rd_word_q <= line_buf[y[0]][rd_idx];
  end

  // Colour pipeline: stage 1 carries blank/odd, stage 2 selects the triplet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= 1'b1;
      odd_q   <= 1'b0;
      rgb_q   <= 3'b000;
    end else begin
      blank_q <= pix_blank;
      odd_q   <= x[0];
      rgb_q   <= blank_q ? 3'b000 : (odd_q ? rd_word_q[5:3] : rd_word_q[2:0]);
    end
  end

  // Sticky underrun next state: a set event wins over a clear.
  always_comb begin
    underrun_d = underrun_q;
    if (under_set) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  // Sticky underrun register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  logic [7:0] cnt_q;

  // Saturating underrun event counter, cleared together with the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (underrun_clr) begin
      cnt_q <= under_set ? 8'd1 : 8'd0;
    end else if (under_set && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign underrun_cnt = cnt_q;
`endif

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign underrun = underrun_q;
  assign RD       = rgb_q[2];
  assign GD       = rgb_q[1];
  assign BD       = rgb_q[0];

endmodule
